// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU op sequencer: state encoding, opcodes,
// error codes and instruction-register field positions.
package seq_pkg;

    localparam int unsigned NumRegs        = 16;
    localparam int unsigned RegW           = 4;
    localparam int unsigned OpcW           = 5;
    localparam int unsigned WaitMaxDefault = 15;

    // IR field positions: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc
    localparam int unsigned OpcMsb = 31;
    localparam int unsigned OpcLsb = 27;
    localparam int unsigned RaLsb  = 23;
    localparam int unsigned RbLsb  = 19;
    localparam int unsigned RcLsb  = 15;

    typedef enum logic [3:0] {
        StIdle,
        StT0,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6,
        StDone
    } state_e;

    localparam logic [OpcW-1:0] OpAdd = 5'b00011;
    localparam logic [OpcW-1:0] OpSub = 5'b00100;
    localparam logic [OpcW-1:0] OpAnd = 5'b00101;
    localparam logic [OpcW-1:0] OpOr  = 5'b00110;
    localparam logic [OpcW-1:0] OpShr = 5'b00111;
    localparam logic [OpcW-1:0] OpShl = 5'b01000;
    localparam logic [OpcW-1:0] OpRor = 5'b01001;
    localparam logic [OpcW-1:0] OpRol = 5'b01010;
    localparam logic [OpcW-1:0] OpMul = 5'b01111;
    localparam logic [OpcW-1:0] OpDiv = 5'b10000;
    localparam logic [OpcW-1:0] OpNeg = 5'b10001;
    localparam logic [OpcW-1:0] OpNot = 5'b10010;

    localparam logic [1:0] ErrOk      = 2'b00;
    localparam logic [1:0] ErrIllegal = 2'b01;
    localparam logic [1:0] ErrTimeout = 2'b10;

    function automatic logic [RegW-1:0] reg_field(input logic [31:0] word,
                                                  input int unsigned lsb);
        return word[lsb +: RegW];
    endfunction

endpackage

// File: rtl/alu_op_sequencer_decode.sv
// Opcode classifier: legality, single-operand flag and HI/LO writeback flag.
// mul/div are only recognised when SEQ_HILO_EN is defined.
module seq_decode
    import seq_pkg::*;
(
    input  logic [OpcW-1:0] opcode,
    output logic            legal,
    output logic            one_operand,
    output logic            hilo
);

    always_comb begin
        legal       = 1'b0;
        one_operand = 1'b0;
        hilo        = 1'b0;
        case (opcode)
            OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShl, OpRor, OpRol: begin
                legal = 1'b1;
            end
            OpNeg, OpNot: begin
                legal       = 1'b1;
                one_operand = 1'b1;
            end
`ifdef SEQ_HILO_EN
            OpMul, OpDiv: begin
                legal = 1'b1;
                hilo  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Moore control-step sequencer: fetch one instruction, then run Ra <= Rb op Rc in T0..T5.
// Define SEQ_HILO_EN to add mul/div with LO written in T5 and HI in an extra T6.
module alu_op_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned WaitMax = WaitMaxDefault
) (
    input  logic            clk,
    input  logic            Clear,
    input  logic            start,
    input  logic            mem_ack,
    input  logic [31:0]     ir,
    output logic            PCout,
    output logic            IncPC,
    output logic            MARin,
    output logic            Zin,
    output logic            Zlowout,
    output logic            Zhiout,
    output logic            PCin,
    output logic            Read,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            HIin,
    output logic            LOin,
    output logic            rout_en,
    output logic [3:0]      rout_sel,
    output logic            rin_en,
    output logic [3:0]      rin_sel,
    output logic [OpcW-1:0] alu_op,
    output logic            busy,
    output logic            done,
    output logic [1:0]      err
);

    localparam int unsigned CntW = (WaitMax > 1) ? $clog2(WaitMax + 1) : 1;

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]      err_q, err_d;

    logic [OpcW-1:0] opcode;
    logic [RegW-1:0] field_ra, field_rb, field_rc;
    logic            op_legal, op_one_operand, op_hilo;
    logic            unused_ir;

    assign opcode    = ir[OpcMsb:OpcLsb];
    assign field_ra  = reg_field(ir, RaLsb);
    assign field_rb  = reg_field(ir, RbLsb);
    assign field_rc  = reg_field(ir, RcLsb);
    assign unused_ir = ^ir[RcLsb-1:0];

    seq_decode u_decode (
        .opcode      (opcode),
        .legal       (op_legal),
        .one_operand (op_one_operand),
        .hilo        (op_hilo)
    );

    always_ff @(posedge clk) begin
        if (Clear) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            err_q      <= ErrOk;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StT0;
                    err_d   = ErrOk;
                end
            end
            StT0: begin
                state_d    = StT1;
                wait_cnt_d = '0;
            end
            StT1: begin
                // mem_ack on the final allowed wait cycle still wins over the timeout
                if (mem_ack) begin
                    state_d    = StT2;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == CntW'(WaitMax - 1)) begin
                    state_d    = StIdle;
                    err_d      = ErrTimeout;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
            end
            StT2: state_d = StT3;
            StT3: begin
                if (op_legal) begin
                    state_d = StT4;
                end else begin
                    state_d = StIdle;
                    err_d   = ErrIllegal;
                end
            end
            StT4: state_d = StT5;
            StT5: state_d = op_hilo ? StT6 : StDone;
            StT6: state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhiout   = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        rout_en  = 1'b0;
        rout_sel = '0;
        rin_en   = 1'b0;
        rin_sel  = '0;
        alu_op   = '0;
        done     = 1'b0;
        busy     = (state_q != StIdle);
        case (state_q)
            StT0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            StT1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            StT2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StT3: begin
                if (op_legal) begin
                    rout_en  = 1'b1;
                    rout_sel = field_rb;
                    Yin      = 1'b1;
                end
            end
            StT4: begin
                rout_en  = 1'b1;
                rout_sel = op_one_operand ? field_rb : field_rc;
                alu_op   = opcode;
                Zin      = 1'b1;
            end
            StT5: begin
                Zlowout = 1'b1;
                if (op_hilo) begin
                    LOin = 1'b1;
                end else begin
                    rin_en  = 1'b1;
                    rin_sel = field_ra;
                end
            end
            StT6: begin
`ifdef SEQ_HILO_EN
                Zhiout = 1'b1;
                HIin   = 1'b1;
`endif
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a per-cycle strobe trace, a table of instructions
// with hand-computed timing/field expectations, and Clear corner cases.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        Clear, start, mem_ack;
    logic [31:0] ir;
    logic        PCout, IncPC, MARin, Zin, Zlowout, Zhiout, PCin, Read;
    logic        MDRin, MDRout, IRin, Yin, HIin, LOin;
    logic        rout_en, rin_en, busy, done;
    logic [3:0]  rout_sel, rin_sel;
    logic [4:0]  alu_op;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    alu_op_sequencer dut (
        .clk      (clk),
        .Clear    (Clear),
        .start    (start),
        .mem_ack  (mem_ack),
        .ir       (ir),
        .PCout    (PCout),
        .IncPC    (IncPC),
        .MARin    (MARin),
        .Zin      (Zin),
        .Zlowout  (Zlowout),
        .Zhiout   (Zhiout),
        .PCin     (PCin),
        .Read     (Read),
        .MDRin    (MDRin),
        .MDRout   (MDRout),
        .IRin     (IRin),
        .Yin      (Yin),
        .HIin     (HIin),
        .LOin     (LOin),
        .rout_en  (rout_en),
        .rout_sel (rout_sel),
        .rin_en   (rin_en),
        .rin_sel  (rin_sel),
        .alu_op   (alu_op),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // strobes order: PCout IncPC MARin Zin Zlowout Zhiout PCin Read MDRin MDRout IRin Yin HIin LOin
    typedef struct packed {
        logic [13:0] strobes;
        logic        rout_en;
        logic [3:0]  rout_sel;
        logic        rin_en;
        logic [3:0]  rin_sel;
        logic [4:0]  alu;
        logic        busy;
        logic        done;
    } step_t;

    typedef struct {
        logic [31:0] ir;
        int ack_delay;
        int start_len;
        int done_at;
        int fall_at;
        int err_end;
        int read_cnt;
        int yin_cnt;
        int rin_cnt;
        int t3_rout;
        int t4_rout;
        int t4_alu;
        int rin_sel;
        int lo_at;
        int hi_at;
    } vec_t;

    typedef struct {
        int done_at;
        int fall_at;
        int err_end;
        int err_c1;
        int read_cnt;
        int yin_cnt;
        int rin_cnt;
        int t3_rout;
        int t4_rout;
        int t4_alu;
        int rin_sel;
        int lo_at;
        int hi_at;
        int stray;
    } obs_t;

    step_t steps[9];
    vec_t  vecs[10];
    obs_t  o;

    function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {opc, ra, rb, rc, 15'b0};
    endfunction

    function automatic step_t outs_now();
        step_t s;
        s.strobes  = {PCout, IncPC, MARin, Zin, Zlowout, Zhiout, PCin, Read,
                      MDRin, MDRout, IRin, Yin, HIin, LOin};
        s.rout_en  = rout_en;
        s.rout_sel = rout_sel;
        s.rin_en   = rin_en;
        s.rin_sel  = rin_sel;
        s.alu      = alu_op;
        s.busy     = busy;
        s.done     = done;
        return s;
    endfunction

    task automatic chk(input string name, input int idx, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, output obs_t r);
        bit ended;
        ended = 1'b0;
        r = '{default: -1};
        r.read_cnt = 0;
        r.yin_cnt  = 0;
        r.rin_cnt  = 0;
        r.stray    = 0;
        ir = v.ir;
        for (int n = 0; n < 40 && !ended; n++) begin
            start   = (n < v.start_len);
            mem_ack = (v.ack_delay >= 0) && (n >= v.ack_delay + 2);
            @(negedge clk);
            if (done && r.done_at < 0) r.done_at = n;
            if (Read) r.read_cnt++;
            if (Yin) begin
                r.yin_cnt++;
                r.t3_rout = rout_en ? int'(rout_sel) : -1;
            end
            if (rin_en) begin
                r.rin_cnt++;
                r.rin_sel = int'(rin_sel);
            end
            if (Zin && n > 1) begin
                r.t4_alu  = int'(alu_op);
                r.t4_rout = rout_en ? int'(rout_sel) : -1;
            end
            if (alu_op != 5'd0 && !(Zin && n > 1)) r.stray++;
            if (LOin) r.lo_at = Zlowout ? n : 100 + n;
            if (HIin || Zhiout) r.hi_at = (HIin && Zhiout) ? n : 100 + n;
            if (n == 1) r.err_c1 = int'(err);
            if (n > 0 && !busy) begin
                r.fall_at = n;
                r.err_end = int'(err);
                ended = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        start   = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic check_vec(input int i, input vec_t v, input obs_t r);
        chk("done_at", i, r.done_at, v.done_at);
        chk("busy_fall", i, r.fall_at, v.fall_at);
        chk("err_end", i, r.err_end, v.err_end);
        chk("err_after_start", i, r.err_c1, 0);
        chk("read_cycles", i, r.read_cnt, v.read_cnt);
        chk("yin_cycles", i, r.yin_cnt, v.yin_cnt);
        chk("rin_en_cycles", i, r.rin_cnt, v.rin_cnt);
        chk("t3_rout_sel", i, r.t3_rout, v.t3_rout);
        chk("t4_rout_sel", i, r.t4_rout, v.t4_rout);
        chk("t4_alu_op", i, r.t4_alu, v.t4_alu);
        chk("rin_sel", i, r.rin_sel, v.rin_sel);
        chk("lo_cycle", i, r.lo_at, v.lo_at);
        chk("hi_cycle", i, r.hi_at, v.hi_at);
        chk("alu_op_outside_t4", i, r.stray, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        steps[0] = '{14'b00000000000000, 1'b0, 4'd0, 1'b0, 4'd0, 5'b00000, 1'b0, 1'b0};
        steps[1] = '{14'b11110000000000, 1'b0, 4'd0, 1'b0, 4'd0, 5'b00000, 1'b1, 1'b0};
        steps[2] = '{14'b00001011100000, 1'b0, 4'd0, 1'b0, 4'd0, 5'b00000, 1'b1, 1'b0};
        steps[3] = '{14'b00000000011000, 1'b0, 4'd0, 1'b0, 4'd0, 5'b00000, 1'b1, 1'b0};
        steps[4] = '{14'b00000000000100, 1'b1, 4'd1, 1'b0, 4'd0, 5'b00000, 1'b1, 1'b0};
        steps[5] = '{14'b00010000000000, 1'b1, 4'd3, 1'b0, 4'd0, 5'b00100, 1'b1, 1'b0};
        steps[6] = '{14'b00001000000000, 1'b0, 4'd0, 1'b1, 4'd2, 5'b00000, 1'b1, 1'b0};
        steps[7] = '{14'b00000000000000, 1'b0, 4'd0, 1'b0, 4'd0, 5'b00000, 1'b1, 1'b1};
        steps[8] = '{14'b00000000000000, 1'b0, 4'd0, 1'b0, 4'd0, 5'b00000, 1'b0, 1'b0};

        // ir, ack_delay, start_len, done, fall, err, read, yin, rin, t3, t4, alu, rin_sel, lo, hi
        vecs[0] = '{32'h2109_8000, 0, 1, 7, 8, 0, 1, 1, 1, 1, 3, 4, 2, -1, -1};
        vecs[1] = '{32'h2109_8000, 4, 6, 11, 12, 0, 5, 1, 1, 1, 3, 4, 2, -1, -1};
        vecs[2] = '{32'h2109_8000, -1, 1, -1, 17, 2, 15, 0, 0, -1, -1, -1, -1, -1, -1};
        vecs[3] = '{mk_ir(5'b00011, 4'd15, 4'd14, 4'd13), 0, 1, 7, 8, 0, 1, 1, 1, 14, 13, 3, 15,
                    -1, -1};
        vecs[4] = '{mk_ir(5'b11111, 4'd1, 4'd2, 4'd3), 0, 1, -1, 5, 1, 1, 0, 0, -1, -1, -1, -1,
                    -1, -1};
        vecs[5] = '{mk_ir(5'b10001, 4'd0, 4'd5, 4'd9), 0, 1, 7, 8, 0, 1, 1, 1, 5, 5, 17, 0,
                    -1, -1};
        vecs[6] = '{mk_ir(5'b10010, 4'd7, 4'd10, 4'd2), 1, 1, 8, 9, 0, 2, 1, 1, 10, 10, 18, 7,
                    -1, -1};
`ifdef SEQ_HILO_EN
        vecs[7] = '{mk_ir(5'b01111, 4'd3, 4'd4, 4'd6), 0, 1, 8, 9, 0, 1, 1, 0, 4, 6, 15, -1,
                    6, 7};
`else
        vecs[7] = '{mk_ir(5'b01111, 4'd3, 4'd4, 4'd6), 0, 1, -1, 5, 1, 1, 0, 0, -1, -1, -1, -1,
                    -1, -1};
`endif
        vecs[8] = '{mk_ir(5'b00000, 4'd0, 4'd0, 4'd0), 0, 1, -1, 5, 1, 1, 0, 0, -1, -1, -1, -1,
                    -1, -1};
        vecs[9] = '{mk_ir(5'b01010, 4'd9, 4'd8, 4'd11), 2, 1, 9, 10, 0, 3, 1, 1, 8, 11, 10, 9,
                    -1, -1};

        // Reset
        Clear = 1'b1; start = 1'b0; mem_ack = 1'b0; ir = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_outputs", 0, int'(outs_now()), 0);
        chk("reset_err", 0, int'(err), 0);
        @(posedge clk);
        #1;
        Clear = 1'b0;

        // Exact per-cycle trace of sub R2 <= R1 - R3 with mem_ack in the first T1 cycle
        ir = 32'h2109_8000;
        for (int n = 0; n < 9; n++) begin
            start   = (n == 0);
            mem_ack = (n >= 2);
            @(negedge clk);
            checks++;
            if (outs_now() !== steps[n]) begin
                errors++;
                $display("FAIL trace_step[%0d]: got %h, expected %h", n, outs_now(), steps[n]);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0; mem_ack = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], o);
            check_vec(i, vecs[i], o);
            if (i == 2) begin
                repeat (3) @(posedge clk);
                #1;
                @(negedge clk);
                chk("timeout_err_held", i, int'(err), 2);
                @(posedge clk);
                #1;
            end
        end

        // Clear in T4 wins over the T4->T5 transition
        ir = 32'h2109_8000;
        for (int n = 0; n < 7; n++) begin
            start   = (n == 0);
            mem_ack = (n >= 2);
            Clear   = (n == 5);
            @(negedge clk);
            if (n == 5) chk("t4_zin_before_clear", 0, int'(Zin), 1);
            if (n == 6) begin
                chk("clear_t4_outputs", 0, int'(outs_now()), 0);
                chk("clear_t4_err", 0, int'(err), 0);
            end
            @(posedge clk);
            #1;
        end
        Clear = 1'b0; start = 1'b0; mem_ack = 1'b0;
        run_vec(vecs[0], o);
        check_vec(100, vecs[0], o);

        // Clear during the T1 wait: no later timeout may fire
        for (int n = 0; n < 26; n++) begin
            start   = (n == 0);
            mem_ack = 1'b0;
            Clear   = (n == 5);
            @(negedge clk);
            if (n == 6) chk("clear_t1_outputs", 0, int'(outs_now()), 0);
            if (n == 25) begin
                chk("clear_t1_err_later", 0, int'(err), 0);
                chk("clear_t1_busy_later", 0, int'(busy), 0);
            end
            @(posedge clk);
            #1;
        end
        Clear = 1'b0; start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
